// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 32x32 register file: clears all registers after reset,
// then merges pipeline writebacks (priority) with buffered multi-cycle results.
module regfile_write_arbiter #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned NUM_REGS   = 32,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_reg,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              md_valid,
   output logic              md_ready,
   input  logic [ADDR_W-1:0] md_reg,
   input  logic [DATA_W-1:0] md_data,
   input  logic [ADDR_W-1:0] rd_reg1,
   input  logic [ADDR_W-1:0] rd_reg2,
   output logic              hazard1,
   output logic              hazard2,
   output logic              init_done,
   output logic              rf_wr_en,
   output logic [ADDR_W-1:0] rf_wr_reg,
   output logic [DATA_W-1:0] rf_wr_data
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] clr_cnt, clr_cnt_next;
   logic              init_done_next;
   logic              rf_wr_en_next;
   logic [ADDR_W-1:0] rf_wr_reg_next;
   logic [DATA_W-1:0] rf_wr_data_next;

   logic [ADDR_W-1:0]   fifo_reg  [FIFO_DEPTH];
   logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifo_vld;
   logic [PTR_W-1:0]    rd_ptr, wr_ptr;
   logic [CNT_W-1:0]    count;

   logic wb_fire, push, enq, pop;

   assign md_ready = (state == RUN) && (count < CNT_W'(FIFO_DEPTH));
   assign push     = md_valid && md_ready;
   assign enq      = push && (md_reg != '0);
   assign wb_fire  = (state == RUN) && wb_en && (wb_reg != '0);

   // Next-state and write-port selection
   always_comb begin
      state_next      = state;
      clr_cnt_next    = clr_cnt;
      init_done_next  = init_done;
      rf_wr_en_next   = 1'b0;
      rf_wr_reg_next  = '0;
      rf_wr_data_next = '0;
      pop             = 1'b0;
      case (state)
         CLEAR: begin
            rf_wr_en_next  = 1'b1;
            rf_wr_reg_next = clr_cnt;
            clr_cnt_next   = clr_cnt + ADDR_W'(1);
            if (clr_cnt == ADDR_W'(NUM_REGS - 1)) begin
               state_next     = RUN;
               init_done_next = 1'b1;
            end
         end
         RUN: begin
            if (wb_fire) begin
               rf_wr_en_next   = 1'b1;
               rf_wr_reg_next  = wb_reg;
               rf_wr_data_next = wb_data;
            end else if (count != '0) begin
               // A superseded head is still popped, just without a write
               pop = 1'b1;
               if (fifo_vld[rd_ptr]) begin
                  rf_wr_en_next   = 1'b1;
                  rf_wr_reg_next  = fifo_reg[rd_ptr];
                  rf_wr_data_next = fifo_data[rd_ptr];
               end
            end
         end
         default: state_next = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= CLEAR;
         clr_cnt    <= '0;
         init_done  <= 1'b0;
         rf_wr_en   <= 1'b0;
         rf_wr_reg  <= '0;
         rf_wr_data <= '0;
      end else begin
         state      <= state_next;
         clr_cnt    <= clr_cnt_next;
         init_done  <= init_done_next;
         rf_wr_en   <= rf_wr_en_next;
         rf_wr_reg  <= rf_wr_reg_next;
         rf_wr_data <= rf_wr_data_next;
      end
   end

   // FIFO control; a wb write kills older entries, a same-cycle push stays valid
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         fifo_vld <= '0;
      end else begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (wb_fire && (fifo_reg[PTR_W'(i)] == wb_reg)) fifo_vld[PTR_W'(i)] <= 1'b0;
         end
         if (pop) begin
            fifo_vld[rd_ptr] <= 1'b0;
            rd_ptr           <= rd_ptr + PTR_W'(1);
         end
         if (enq) begin
            fifo_vld[wr_ptr] <= 1'b1;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         case ({enq, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         fifo_reg[wr_ptr]  <= md_reg;
         fifo_data[wr_ptr] <= md_data;
      end
   end

   // Read-port hazards against buffered, still-valid entries
   always_comb begin
      hazard1 = 1'b0;
      hazard2 = 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
         if (fifo_vld[PTR_W'(i)] && (fifo_reg[PTR_W'(i)] == rd_reg1) && (rd_reg1 != '0))
            hazard1 = 1'b1;
         if (fifo_vld[PTR_W'(i)] && (fifo_reg[PTR_W'(i)] == rd_reg2) && (rd_reg2 != '0))
            hazard2 = 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic
// against a queue-based model of the write-port rules.
module tb_regfile_write_arbiter;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned ADDR_W     = 5;
   localparam int unsigned NUM_REGS   = 32;
   localparam int unsigned FIFO_DEPTH = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              wb_en = 1'b0;
   logic [ADDR_W-1:0] wb_reg = '0;
   logic [DATA_W-1:0] wb_data = '0;
   logic              md_valid = 1'b0;
   logic              md_ready;
   logic [ADDR_W-1:0] md_reg = '0;
   logic [DATA_W-1:0] md_data = '0;
   logic [ADDR_W-1:0] rd_reg1 = '0;
   logic [ADDR_W-1:0] rd_reg2 = '0;
   logic              hazard1, hazard2, init_done;
   logic              rf_wr_en;
   logic [ADDR_W-1:0] rf_wr_reg;
   logic [DATA_W-1:0] rf_wr_data;

   regfile_write_arbiter #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
      .md_valid(md_valid), .md_ready(md_ready), .md_reg(md_reg), .md_data(md_data),
      .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .hazard1(hazard1), .hazard2(hazard2),
      .init_done(init_done),
      .rf_wr_en(rf_wr_en), .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data)
   );

   always #5 clk = ~clk;

   // Register file driven by the arbiter, committing on the falling edge
   logic [DATA_W-1:0] rf_mem [NUM_REGS];
   always @(negedge clk) if (rf_wr_en === 1'b1) rf_mem[rf_wr_reg] <= rf_wr_data;

   typedef struct {
      logic [ADDR_W-1:0] r;
      logic [DATA_W-1:0] d;
      bit                v;
   } ent_t;

   ent_t              mq[$];
   bit                m_run;
   int                m_clr;
   logic              exp_en;
   logic [ADDR_W-1:0] exp_reg;
   logic [DATA_W-1:0] exp_data;
   logic [DATA_W-1:0] exp_mem [NUM_REGS];
   int                checks = 0;
   int                passes = 0;

   function automatic logic exp_md_ready();
      return m_run && (mq.size() < FIFO_DEPTH);
   endfunction

   function automatic logic exp_hz(input logic [ADDR_W-1:0] r);
      if (r == 0) return 1'b0;
      foreach (mq[i]) if (mq[i].v && mq[i].r == r) return 1'b1;
      return 1'b0;
   endfunction

   // Advance one clock, applying the write-port rules to the model first
   task automatic tick();
      ent_t e;
      bit   take;
      if (rst) begin
         mq.delete();
         m_run = 0; m_clr = 0;
         exp_en = 0; exp_reg = '0; exp_data = '0;
      end else if (!m_run) begin
         exp_en = 1; exp_reg = ADDR_W'(m_clr); exp_data = '0;
         exp_mem[m_clr] = '0;
         m_clr++;
         if (m_clr == NUM_REGS) m_run = 1;
      end else begin
         take = (mq.size() < FIFO_DEPTH) && md_valid;
         exp_en = 0; exp_reg = '0; exp_data = '0;
         if (wb_en && wb_reg != 0) begin
            exp_en = 1; exp_reg = wb_reg; exp_data = wb_data;
            foreach (mq[i]) if (mq[i].r == wb_reg) mq[i].v = 0;
         end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.v) begin exp_en = 1; exp_reg = e.r; exp_data = e.d; end
         end
         if (exp_en) exp_mem[exp_reg] = exp_data;
         if (take && md_reg != 0) mq.push_back('{md_reg, md_data, 1'b1});
      end
      @(posedge clk); #1;
   endtask

   task automatic idle();
      wb_en = 0; md_valid = 0;
   endtask

   task automatic test_reset();
      rst = 1; idle(); rd_reg1 = 5'd1; rd_reg2 = 5'd2;
      tick();
      checks++;
      if ({rf_wr_en, rf_wr_reg, rf_wr_data} !== {1'b0, 5'd0, 32'd0})
         $display("FAIL reset_rf: got en=%0b reg=%0d data=%h want 0/0/0", rf_wr_en, rf_wr_reg, rf_wr_data);
      else passes++;
      checks++;
      if ({init_done, md_ready, hazard1, hazard2} !== 4'b0000)
         $display("FAIL reset_flags: got init/ready/hz1/hz2=%b want 0000", {init_done, md_ready, hazard1, hazard2});
      else passes++;
      rst = 0;
      for (int i = 0; i < NUM_REGS; i++) begin
         wb_en = 1; wb_reg = 5'd4; wb_data = 32'hBAD0_0004;
         tick();
         checks++;
         if ({rf_wr_en, rf_wr_reg, rf_wr_data} !== {1'b1, 5'(i), 32'd0})
            $display("FAIL clear_write[%0d]: got en=%0b reg=%0d data=%h", i, rf_wr_en, rf_wr_reg, rf_wr_data);
         else passes++;
         checks++;
         if (init_done !== (i == NUM_REGS - 1))
            $display("FAIL clear_init_done[%0d]: got %b want %b", i, init_done, (i == NUM_REGS - 1));
         else passes++;
      end
      idle();
      tick();
      checks++;
      if ({rf_wr_en, init_done} !== 2'b01)
         $display("FAIL clear_end: got en=%b init_done=%b want 0 1", rf_wr_en, init_done);
      else passes++;
      @(negedge clk); #1;
      for (int i = 0; i < NUM_REGS; i++) begin
         checks++;
         if (rf_mem[i] !== 32'd0) $display("FAIL clear_mem[%0d]: got %h want 0", i, rf_mem[i]);
         else passes++;
      end
   endtask

   task automatic test_priority();
      idle(); md_valid = 1; md_reg = 5'd7; md_data = 32'h77; rd_reg1 = 5'd7;
      #1;
      checks++;
      if (md_ready !== 1'b1) $display("FAIL prio_ready: got %b want 1", md_ready); else passes++;
      tick();
      checks++;
      if ({rf_wr_en, hazard1} !== 2'b01) $display("FAIL prio_buffer: got en=%b hz=%b want 0 1", rf_wr_en, hazard1);
      else passes++;
      md_valid = 0; wb_en = 1; wb_reg = 5'd5; wb_data = 32'hAAAA_0005;
      tick();
      checks++;
      if ({rf_wr_en, rf_wr_reg, rf_wr_data, hazard1} !== {1'b1, 5'd5, 32'hAAAA_0005, 1'b1})
         $display("FAIL prio_wb_first: got en=%b reg=%0d data=%h hz=%b", rf_wr_en, rf_wr_reg, rf_wr_data, hazard1);
      else passes++;
      wb_en = 0;
      tick();
      checks++;
      if ({rf_wr_en, rf_wr_reg, rf_wr_data, hazard1} !== {1'b1, 5'd7, 32'h77, 1'b0})
         $display("FAIL prio_md_next: got en=%b reg=%0d data=%h hz=%b", rf_wr_en, rf_wr_reg, rf_wr_data, hazard1);
      else passes++;
      @(negedge clk); #1;
      checks++;
      if ({rf_mem[5], rf_mem[7]} !== {32'hAAAA_0005, 32'h77})
         $display("FAIL prio_mem: got r5=%h r7=%h", rf_mem[5], rf_mem[7]);
      else passes++;
   endtask

   task automatic test_backpressure();
      idle(); wb_en = 1; wb_reg = 5'd3; wb_data = 32'h3333_0000; md_valid = 1;
      for (int k = 0; k < 4; k++) begin
         md_reg = 5'(10 + k); md_data = 32'h1000 + k;
         #1;
         checks++;
         if (md_ready !== (k < 2)) $display("FAIL bp_ready[%0d]: got %b want %b", k, md_ready, (k < 2));
         else passes++;
         tick();
         checks++;
         if ({rf_wr_en, rf_wr_reg} !== {1'b1, 5'd3}) $display("FAIL bp_wb[%0d]: got en=%b reg=%0d", k, rf_wr_en, rf_wr_reg);
         else passes++;
      end
      idle();
      tick();
      checks++;
      if ({rf_wr_en, rf_wr_reg, rf_wr_data, md_ready} !== {1'b1, 5'd10, 32'h1000, 1'b1})
         $display("FAIL bp_drain0: got en=%b reg=%0d data=%h ready=%b", rf_wr_en, rf_wr_reg, rf_wr_data, md_ready);
      else passes++;
      tick();
      checks++;
      if ({rf_wr_en, rf_wr_reg, rf_wr_data} !== {1'b1, 5'd11, 32'h1001})
         $display("FAIL bp_drain1: got en=%b reg=%0d data=%h", rf_wr_en, rf_wr_reg, rf_wr_data);
      else passes++;
      tick();
      checks++;
      if (rf_wr_en !== 1'b0) $display("FAIL bp_empty: got en=%b want 0", rf_wr_en); else passes++;
   endtask

   task automatic test_supersede();
      idle(); md_valid = 1; md_reg = 5'd9; md_data = 32'h11; rd_reg2 = 5'd9;
      tick();
      checks++;
      if (hazard2 !== 1'b1) $display("FAIL sup_hazard_set: got %b want 1", hazard2); else passes++;
      md_valid = 0; wb_en = 1; wb_reg = 5'd9; wb_data = 32'h22;
      tick();
      checks++;
      if ({rf_wr_en, rf_wr_reg, rf_wr_data, hazard2} !== {1'b1, 5'd9, 32'h22, 1'b0})
         $display("FAIL sup_wb: got en=%b reg=%0d data=%h hz=%b", rf_wr_en, rf_wr_reg, rf_wr_data, hazard2);
      else passes++;
      idle();
      tick();
      checks++;
      if (rf_wr_en !== 1'b0) $display("FAIL sup_dead_pop: got en=%b want 0", rf_wr_en); else passes++;
      @(negedge clk); #1;
      checks++;
      if (rf_mem[9] !== 32'h22) $display("FAIL sup_mem: got %h want 22", rf_mem[9]); else passes++;
   endtask

   task automatic test_zero_reg();
      idle(); wb_en = 1; wb_reg = 5'd0; wb_data = 32'hFFFF;
      md_valid = 1; md_reg = 5'd0; md_data = 32'h1234; rd_reg1 = 5'd0;
      #1;
      checks++;
      if (md_ready !== 1'b1) $display("FAIL zero_handshake: got %b want 1", md_ready); else passes++;
      tick();
      checks++;
      if ({rf_wr_en, hazard1} !== 2'b00) $display("FAIL zero_wb: got en=%b hz=%b want 0 0", rf_wr_en, hazard1);
      else passes++;
      idle();
      tick();
      checks++;
      if (rf_wr_en !== 1'b0) $display("FAIL zero_md: got en=%b want 0", rf_wr_en); else passes++;
      @(negedge clk); #1;
      checks++;
      if (rf_mem[0] !== 32'd0) $display("FAIL zero_mem: got %h want 0", rf_mem[0]); else passes++;
   endtask

   task automatic test_midrun_reset();
      idle(); wb_en = 1; wb_reg = 5'd3; md_valid = 1;
      md_reg = 5'd20; md_data = 32'hDEAD_0020;
      tick();
      md_reg = 5'd21; md_data = 32'hDEAD_0021;
      tick();
      rd_reg1 = 5'd20; rd_reg2 = 5'd21;
      #1;
      checks++;
      if ({md_ready, hazard1, hazard2} !== 3'b011)
         $display("FAIL mrst_full: got ready/hz1/hz2=%b want 011", {md_ready, hazard1, hazard2});
      else passes++;
      rst = 1; idle();
      tick();
      checks++;
      if ({md_ready, init_done, hazard1, hazard2, rf_wr_en} !== 5'b00000)
         $display("FAIL mrst_flags: got ready/init/hz1/hz2/en=%b want 00000", {md_ready, init_done, hazard1, hazard2, rf_wr_en});
      else passes++;
      rst = 0;
      for (int i = 0; i < NUM_REGS; i++) begin
         tick();
         checks++;
         if ({rf_wr_en, rf_wr_reg, rf_wr_data} !== {1'b1, 5'(i), 32'd0})
            $display("FAIL mrst_clear[%0d]: got en=%b reg=%0d data=%h", i, rf_wr_en, rf_wr_reg, rf_wr_data);
         else passes++;
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (rf_wr_en !== 1'b0) $display("FAIL mrst_no_stale[%0d]: got en=%b want 0", i, rf_wr_en); else passes++;
      end
      @(negedge clk); #1;
      checks++;
      if ({rf_mem[20], rf_mem[21]} !== 64'd0) $display("FAIL mrst_mem: got r20=%h r21=%h want 0", rf_mem[20], rf_mem[21]);
      else passes++;
   endtask

   task automatic test_random();
      for (int n = 0; n < 800; n++) begin
         rst      = ($urandom_range(0, 299) == 0);
         wb_en    = ($urandom_range(0, 9) < 4);
         wb_reg   = 5'($urandom_range(0, 7));
         wb_data  = $urandom;
         md_valid = ($urandom_range(0, 1) == 1);
         md_reg   = 5'($urandom_range(0, 7));
         md_data  = $urandom;
         rd_reg1  = 5'($urandom_range(0, 7));
         rd_reg2  = 5'($urandom_range(0, 7));
         #1;
         checks++;
         if ({md_ready, hazard1, hazard2, init_done} !== {exp_md_ready(), exp_hz(rd_reg1), exp_hz(rd_reg2), m_run})
            $display("FAIL rand_comb[%0d]: got ready/hz1/hz2/init=%b want %b", n,
                     {md_ready, hazard1, hazard2, init_done}, {exp_md_ready(), exp_hz(rd_reg1), exp_hz(rd_reg2), m_run});
         else passes++;
         tick();
         checks++;
         if (rf_wr_en !== exp_en || (exp_en && {rf_wr_reg, rf_wr_data} !== {exp_reg, exp_data}))
            $display("FAIL rand_write[%0d]: got en=%b reg=%0d data=%h want en=%b reg=%0d data=%h", n,
                     rf_wr_en, rf_wr_reg, rf_wr_data, exp_en, exp_reg, exp_data);
         else passes++;
      end
      rst = 0; idle();
      for (int i = 0; i < NUM_REGS + 4; i++) tick();
      @(negedge clk); #1;
      for (int i = 0; i < NUM_REGS; i++) begin
         checks++;
         if (rf_mem[i] !== exp_mem[i]) $display("FAIL rand_mem[%0d]: got %h want %h", i, rf_mem[i], exp_mem[i]);
         else passes++;
      end
   endtask

   initial begin
      for (int i = 0; i < NUM_REGS; i++) begin
         rf_mem[i]  = 'x;
         exp_mem[i] = 'x;
      end
      @(posedge clk); #1;
      test_reset();
      test_priority();
      test_backpressure();
      test_supersede();
      test_zero_reg();
      test_midrun_reset();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
      $fatal(1);
   end

endmodule
